// File: rtl/alu_pkg.sv
// Shared constants for the execute stage: data/register widths, opcodes and
// the execute FSM state enumeration.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned DATA_W x DATA_W shift-add multiplier, one partial product per cycle.
// done is asserted during the last step; product is valid in that same cycle.
module seq_multiplier
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_W - 1);

  logic [2*DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d, partial;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]       count_q, count_d;
  logic                busy_q, busy_d;

  assign partial = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy    = busy_q;
  assign done    = busy_q && (count_q == LAST_STEP);
  assign product = partial;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{DATA_W{1'b0}}, a};
      mplier_d = b;
      count_d  = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = partial;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: inline single-cycle ALU with registered write-back request.
// EXEC_MUL_EN builds the 17-cycle MUL path (seq_multiplier + MUL state).
//   state | meaning
//   IDLE  | ready; single-cycle ops retire one cycle after accept
//   MUL   | multiplier stepping, upstream stalled via in_ready
module execute_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [REG_AW-1:0] in_rd,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_zero,
  output logic              wb_carry
);

  logic [DATA_W-1:0] alu_res;
  logic [DATA_W:0]   alu_wide;
  logic              alu_c, alu_we, accept;
  logic [3:0]        sh;

  logic              wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_zero_q, wb_zero_d, wb_carry_q, wb_carry_d;

`ifdef EXEC_MUL_EN
  state_e              state_q, state_d;
  logic [REG_AW-1:0]   mul_rd_q, mul_rd_d;
  logic                mul_start, mul_busy, mul_done;
  logic [2*DATA_W-1:0] mul_product;

  seq_multiplier u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (in_a),
    .b       (in_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign in_ready = (state_q == IDLE) && !mul_busy;
`else
  assign in_ready = 1'b1;
`endif

  assign accept = in_valid && in_ready;
  assign sh     = in_b[3:0];

  always_comb begin
    alu_res  = '0;
    alu_wide = '0;
    alu_c    = 1'b0;
    alu_we   = 1'b1;
    case (in_op)
      OP_ADD: begin
        alu_wide = {1'b0, in_a} + {1'b0, in_b};
        alu_res  = alu_wide[DATA_W-1:0];
        alu_c    = alu_wide[DATA_W];
      end
      OP_SUB: begin
        alu_res = in_a - in_b;
        alu_c   = in_a < in_b;
      end
      OP_AND: alu_res = in_a & in_b;
      OP_OR:  alu_res = in_a | in_b;
      OP_XOR: alu_res = in_a ^ in_b;
      OP_NOT: alu_res = ~in_a;
      // Extra bit beside the data catches the last bit shifted out (0 for sh=0).
      OP_SHL: begin
        alu_wide = {1'b0, in_a} << sh;
        alu_res  = alu_wide[DATA_W-1:0];
        alu_c    = alu_wide[DATA_W];
      end
      OP_SHR: begin
        alu_wide = {in_a, 1'b0} >> sh;
        alu_res  = alu_wide[DATA_W:1];
        alu_c    = alu_wide[0];
      end
      OP_MOV: alu_res = in_b;
      default: alu_we = 1'b0;
    endcase
  end

  always_comb begin
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_zero_d  = wb_zero_q;
    wb_carry_d = wb_carry_q;
`ifdef EXEC_MUL_EN
    state_d   = state_q;
    mul_rd_d  = mul_rd_q;
    mul_start = 1'b0;
    if (state_q == MUL) begin
      if (mul_done) begin
        wb_valid_d = 1'b1;
        wb_we_d    = 1'b1;
        wb_rd_d    = mul_rd_q;
        wb_data_d  = mul_product[DATA_W-1:0];
        wb_zero_d  = mul_product[DATA_W-1:0] == '0;
        wb_carry_d = |mul_product[2*DATA_W-1:DATA_W];
        state_d    = IDLE;
      end
    end else if (accept && in_op == OP_MUL) begin
      mul_start = 1'b1;
      mul_rd_d  = in_rd;
      state_d   = MUL;
    end else
`endif
    if (accept) begin
      wb_valid_d = 1'b1;
      wb_we_d    = alu_we;
      wb_rd_d    = in_rd;
      wb_data_d  = alu_res;
      wb_zero_d  = alu_we && (alu_res == '0);
      wb_carry_d = alu_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_zero_q  <= 1'b0;
      wb_carry_q <= 1'b0;
`ifdef EXEC_MUL_EN
      state_q    <= IDLE;
      mul_rd_q   <= '0;
`endif
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_zero_q  <= wb_zero_d;
      wb_carry_q <= wb_carry_d;
`ifdef EXEC_MUL_EN
      state_q    <= state_d;
      mul_rd_q   <= mul_rd_d;
`endif
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign wb_zero  = wb_zero_q;
  assign wb_carry = wb_carry_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases then random traffic, checked against
// an arithmetic reference model of results, flags and MUL stall timing.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [3:0]  in_op, in_rd, wb_rd;
  logic [15:0] in_a, in_b, wb_data;
  logic        wb_valid, wb_we, wb_zero, wb_carry;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          e_valid, e_we, e_zero, e_carry, just_reset;
  bit          e_ready = 1'b1;
  int unsigned e_data, e_rd, m_data, m_rd;
  bit          m_carry;
  int          mul_left = 0;

`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  execute_stage dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_rd    (in_rd),
    .wb_valid (wb_valid),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_zero  (wb_zero),
    .wb_carry (wb_carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_op(input int unsigned op, input int unsigned a, input int unsigned b,
                          output int unsigned d, output bit c, output bit we, output bit is_mul);
    int unsigned s, p;
    s = b % 16;
    d = 0; c = 1'b0; we = 1'b1; is_mul = 1'b0;
    case (op)
      0: begin p = a + b; d = p % 65536; c = (p >= 65536); end
      1: begin d = (a + 65536 - b) % 65536; c = (a < b); end
      2: d = a & b;
      3: d = a | b;
      4: d = a ^ b;
      5: d = 65535 - a;
      6: begin d = (a << s) % 65536; c = (s != 0) && (((a >> (16 - s)) & 1) == 1); end
      7: begin d = a >> s; c = (s != 0) && (((a >> (s - 1)) & 1) == 1); end
      8: d = b;
      9: begin
        if (MUL_EN) begin
          p = a * b; d = p % 65536; c = (p >= 65536); is_mul = 1'b1;
        end else we = 1'b0;
      end
      default: we = 1'b0;
    endcase
  endtask

  task automatic step(input bit r, input bit v, input int unsigned op,
                      input int unsigned a, input int unsigned b, input int unsigned rd);
    int unsigned d;
    bit c, we, is_mul;
    rst = r; in_valid = v; in_op = op[3:0]; in_a = a[15:0]; in_b = b[15:0]; in_rd = rd[3:0];
    @(posedge clk);
    if (r) begin
      e_valid = 1'b0; e_ready = 1'b1; mul_left = 0; just_reset = 1'b1;
    end else begin
      just_reset = 1'b0;
      if (mul_left > 0) begin
        mul_left--;
        e_valid = (mul_left == 0);
        e_ready = (mul_left == 0);
        if (e_valid) begin
          e_we = 1'b1; e_rd = m_rd; e_data = m_data; e_carry = m_carry; e_zero = (m_data == 0);
        end
      end else if (v) begin
        model_op(op, a, b, d, c, we, is_mul);
        if (is_mul) begin
          mul_left = 16; e_ready = 1'b0; e_valid = 1'b0;
          m_rd = rd; m_data = d; m_carry = c;
        end else begin
          e_valid = 1'b1; e_we = we; e_rd = rd; e_data = d; e_carry = c;
          e_zero = we && (d == 0);
        end
      end else e_valid = 1'b0;
    end
    @(negedge clk);
    chk("in_ready", in_ready, e_ready);
    chk("wb_valid", wb_valid, e_valid);
    if (just_reset) begin
      chk("rst_we", wb_we, 0);
      chk("rst_rd", wb_rd, 0);
      chk("rst_data", wb_data, 0);
      chk("rst_zero", wb_zero, 0);
      chk("rst_carry", wb_carry, 0);
    end
    if (e_valid) begin
      chk("wb_we", wb_we, e_we);
      if (e_we) chk("wb_rd", wb_rd, e_rd);
      chk("wb_data", wb_data, e_data);
      chk("wb_zero", wb_zero, e_zero);
      chk("wb_carry", wb_carry, e_carry);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
    // reset with in_valid held high
    step(1, 1, 0, 16'h1234, 16'h1111, 2);
    step(1, 1, 0, 16'h1234, 16'h1111, 2);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 16'hFFFF, 16'h0001, 3);
    step(0, 1, 1, 5, 7, 1);
    step(0, 1, 6, 16'h8001, 1, 2);
    step(0, 1, 5, 16'h00FF, 0, 5);
    step(0, 0, 0, 0, 0, 0);
    // MUL then ADD held on the inputs until accepted in the result cycle
    step(0, 1, 9, 16'h0100, 16'h0100, 7);
    for (int i = 0; i < 17; i++) step(0, 1, 0, 2, 3, 8);
    step(0, 0, 0, 0, 0, 0);
    // MUL aborted by reset at cycle 8
    step(0, 1, 9, 300, 200, 6);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 12, 16'hAAAA, 16'h5555, 4);
    step(0, 1, 9, 3, 4, 9);
    step(0, 1, 7, 16'h8001, 0, 1);
    step(0, 1, 7, 16'h8001, 15, 1);
    step(0, 1, 6, 16'h0001, 15, 1);
    step(0, 1, 0, 16'h8000, 16'h8000, 10);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 700; i++) begin
      int unsigned a, b;
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF * $urandom_range(0, 1) : $urandom_range(0, 65535);
      b = ($urandom_range(0, 7) == 0) ? 16'hFFFF * $urandom_range(0, 1) : $urandom_range(0, 65535);
      step(($urandom_range(0, 80) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 15), a, b, $urandom_range(0, 15));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the pipelined ALU. Accepts one decoded instruction per cycle (opcode, two operands, destination register) from the decode/register-read stage. Computes the result and presents it, registered, to `write_back` as a write request. Single-cycle ops take 1 cycle; an optional multi-cycle shift-add multiplier stalls upstream through `in_ready`.

## Interface
- `DATA_W`, 16: operand/result width; matches `write_back` register width.
- `REG_AW`, 4: destination register address width; 16 registers, matching `pos_show`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream instruction valid.
- `in_ready`  out  1  stage can accept an instruction this cycle.
- `in_op`  in  4  opcode.
- `in_a`, `in_b`  in  DATA_W  operands.
- `in_rd`  in  REG_AW  destination register.
- `wb_valid`  out  1  result valid to `write_back`, one-cycle pulse per instruction.
- `wb_we`  out  1  register write enable; qualified by `wb_valid`.
- `wb_rd`  out  REG_AW  destination register.
- `wb_data`  out  DATA_W  result.
- `wb_zero`, `wb_carry`  out  1  flags for this result.

## Operation
- Accept: `in_valid && in_ready` at a rising edge. `write_back` never back-pressures.
- Opcodes:
  - 0 ADD: a+b; carry = bit DATA_W of the sum.
  - 1 SUB: a−b; carry = borrow (a<b, unsigned).
  - 2 AND, 3 OR, 4 XOR, 5 NOT (~a): carry = 0.
  - 6 SHL: a<<b[3:0]; carry = last bit shifted out, or 0 if shift is 0.
  - 7 SHR: logical; same carry rule as SHL.
  - 8 MOV: b; carry = 0.
  - 9 MUL: low DATA_W bits of a*b, unsigned; carry = 1 if the high half is nonzero.
  - 10–15 NOP: `wb_valid`=1, `wb_we`=0, `wb_data`=0, flags 0.
- `wb_zero` = (`wb_data`==0) for writing ops.
- All results wrap modulo 2^DATA_W.
- FSM states:
  - IDLE: `in_ready`=1. Non-MUL accept → registered output next cycle, stay IDLE. MUL accept → MUL, count=0.
  - MUL: `in_ready`=0. One shift-add step per cycle. When count=15, register the result, assert `wb_valid`, go to IDLE.
- `in_*` inputs are ignored while `in_ready`=0. Upstream must hold them.

## Timing
- Reset values: `in_ready`=1; `wb_valid`, `wb_we`, `wb_zero`, `wb_carry`=0; `wb_rd`=0; `wb_data`=0; state IDLE, count 0.
- Single-cycle op accepted at edge E: outputs valid in the cycle after E, for exactly one cycle unless another op is accepted at E+1.
- Back-to-back single-cycle ops sustain 1 result/cycle.
- MUL accepted at edge E:
  - `in_ready` is low from E+1 through E+16.
  - Result is valid in the cycle after E+16, with `in_ready`=1 in that same cycle.
  - Latency is 17 cycles.
- An instruction accepted in the MUL result cycle produces its output one cycle later, with no gap.
- `rst` asserted during MUL aborts the operation: no `wb_valid` for it, and all reset values apply next cycle.
- `rst` has priority over any accept on the same edge.

## Configuration
- `EXEC_MUL_EN` defined: opcode 9 uses `seq_multiplier` and the MUL state as described.
- `EXEC_MUL_EN` undefined:
  - Opcode 9 behaves as NOP (`wb_we`=0).
  - The MUL state and multiplier are not built.
  - `in_ready` is constant 1.

## Structure
- Shared package `alu_pkg`:
  - `DATA_W` and `REG_AW` constants.
  - Opcode localparams OP_ADD…OP_MUL.
  - The FSM state enumeration (IDLE, MUL).
- Sub-module `seq_multiplier`:
  - Inputs: start, a, b.
  - Outputs: busy, done, product of 2·DATA_W bits.
  - 16-step shift-add; synchronous `rst`.
- The combinational ALU stays inline in `execute_stage`.

## Test plan
- Reset: `rst`=1 for 2 cycles → all outputs 0, `in_ready`=1; with `in_valid` high during reset, no `wb_valid`.
- ADD 0xFFFF+0x0001 rd=3 → next cycle `wb_data`=0x0000, `wb_zero`=1, `wb_carry`=1, `wb_rd`=3, `wb_we`=1.
- Back-to-back SUB 5−7, SHL 0x8001<<1, NOT 0x00FF → 3 consecutive `wb_valid` cycles:
  - SUB: 0xFFFE, carry 1.
  - SHL: 0x0002, carry 1.
  - NOT: 0xFF00.
- MUL 0x0100*0x0100 rd=7 (`EXEC_MUL_EN`) → `in_ready` low 16 cycles; result in cycle 17 is 0x0000, carry 1, zero 1. Then ADD 2+3 accepted in the result cycle → 0x0005 one cycle later.
- MUL 300*200 with `rst` pulsed at cycle 8 → no `wb_valid`; `in_ready`=1 the cycle after reset.
- Opcode 12 rd=4 → `wb_valid`=1, `wb_we`=0. Without `EXEC_MUL_EN`, opcode 9 → `wb_we`=0 and `in_ready` is never low.
